matrix_inv_sched: RTL and testbench

// - Shares one 2x2 Q2.14 matrix_inv core between NREQ requesters. Round-robin arbitration, one job in flight.
// - Latches the winner's operands, pulses the core start, waits for done or timeout, then returns result/error tagged with requester id.
// - Sits between the system request ports and the single matrix_inv instance.

---
 rtl/matrix_inv_pkg.sv | 28 ++
 rtl/matrix_inv_sched_rr_arbiter.sv | 39 +++
 rtl/matrix_inv_sched.sv | 202 ++++++++++++++++++++
 tb/tb_matrix_inv_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_inv_pkg.sv
// Shared constants and types for the matrix_inv scheduler.
// Q2.14 number format, scheduler FSM encoding, default job timeout.
// No ports; imported by the scheduler and its arbiter.
package matrix_inv_pkg;

    // Q2.14 signed fixed point: 2 integer bits (incl. sign), 14 fraction bits.
    localparam int IN_I = 2;
    localparam int IN_F = 14;
    localparam int DW   = IN_I + IN_F;

    localparam logic [DW-1:0] ONE_Q214 = DW'(1) << IN_F;

    // Cycles a job may sit in WAIT before it is aborted.
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_e;

    // v+1 modulo n, for round-robin pointer advance.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/matrix_inv_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is consumed.
// Ports: req (per-requester request), ptr (search start), grant (one-hot),
//        grant_id (encoded winner), grant_vld (any request present).
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_vld
);

    // slot[i] is the requester examined i-th, i.e. (ptr + i) mod NREQ.
    logic [IDW-1:0] slot [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        logic [IDW:0] sum;
        assign sum     = {1'b0, ptr} + (IDW+1)'(i);
        assign slot[i] = IDW'((sum >= (IDW+1)'(NREQ)) ? sum - (IDW+1)'(NREQ) : sum);
    end

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_vld && req[slot[i]]) begin
                grant_vld = 1'b1;
                grant_id  = slot[i];
            end
        end
        grant[grant_id] = grant_vld;
    end

endmodule

// File: rtl/matrix_inv_sched.sv
// Shares one 2x2 Q2.14 matrix_inv core between NREQ requesters, one job in flight.
// Latency: accept -> rsp_valid = 2 + core cycles; TIMEOUT+2 when the core never answers.
// Backpressure: rsp_* held while rsp_ready=0; no new request accepted until the response handshake.
// Ports: clk/reset (async active-high); req_valid/req_ready + packed req_a..d per requester;
//        inv_start/inv_a..d to the core, inv_done/inv_*_inv/inv_error back from it;
//        rsp_valid/rsp_ready with rsp_id, rsp_a..d, rsp_error, rsp_tmo; busy = not idle.
module matrix_inv_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ*DW-1:0] req_c,
    input  logic [NREQ*DW-1:0] req_d,
    output logic               inv_start,
    output logic [DW-1:0]      inv_a,
    output logic [DW-1:0]      inv_b,
    output logic [DW-1:0]      inv_c,
    output logic [DW-1:0]      inv_d,
    input  logic               inv_done,
    input  logic [DW-1:0]      inv_a_inv,
    input  logic [DW-1:0]      inv_b_inv,
    input  logic [DW-1:0]      inv_c_inv,
    input  logic [DW-1:0]      inv_d_inv,
    input  logic               inv_error,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_a,
    output logic [DW-1:0]      rsp_b,
    output logic [DW-1:0]      rsp_c,
    output logic [DW-1:0]      rsp_d,
    output logic               rsp_error,
    output logic               rsp_tmo,
    output logic               busy
);
    import matrix_inv_pkg::*;

    localparam int             TW       = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    sched_state_e   state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] job_id_q, job_id_d;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic           inv_start_q, inv_start_d;
    logic [DW-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d, op_d_q, op_d_d;
    logic [DW-1:0]  res_a_q, res_a_d, res_b_q, res_b_d, res_c_q, res_c_d, res_d_q, res_d_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_error_q, rsp_error_d;
    logic           rsp_tmo_q, rsp_tmo_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_vld;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    // The accept pulse is only meaningful in IDLE; gating with reset keeps
    // every output at zero while reset is held even if requests are pending.
    assign req_ready = (state_q == S_IDLE && !reset) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        job_id_d    = job_id_q;
        tmo_cnt_d   = tmo_cnt_q;
        inv_start_d = 1'b0;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_c_d      = op_c_q;
        op_d_d      = op_d_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_c_d     = res_c_q;
        res_d_d     = res_d_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        rsp_tmo_d   = rsp_tmo_q;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    op_a_d      = req_a[grant_id*DW +: DW];
                    op_b_d      = req_b[grant_id*DW +: DW];
                    op_c_d      = req_c[grant_id*DW +: DW];
                    op_d_d      = req_d[grant_id*DW +: DW];
                    job_id_d    = grant_id;
                    // Registered so the pulse lines up exactly with ISSUE.
                    inv_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the timeout cycle still counts as a result.
                if (inv_done) begin
                    rsp_error_d = inv_error;
                    rsp_tmo_d   = 1'b0;
                    res_a_d     = inv_error ? '0 : inv_a_inv;
                    res_b_d     = inv_error ? '0 : inv_b_inv;
                    res_c_d     = inv_error ? '0 : inv_c_inv;
                    res_d_d     = inv_error ? '0 : inv_d_inv;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_error_d = 1'b0;
                    rsp_tmo_d   = 1'b1;
                    res_a_d     = '0;
                    res_b_d     = '0;
                    res_c_d     = '0;
                    res_d_d     = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Next search starts just past the requester just served.
                    rr_ptr_d    = IDW'(wrap_inc(32'(job_id_q), NREQ));
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            job_id_q    <= '0;
            tmo_cnt_q   <= '0;
            inv_start_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_c_q      <= '0;
            op_d_q      <= '0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_c_q     <= '0;
            res_d_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            job_id_q    <= job_id_d;
            tmo_cnt_q   <= tmo_cnt_d;
            inv_start_q <= inv_start_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_c_q      <= op_c_d;
            op_d_q      <= op_d_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            res_c_q     <= res_c_d;
            res_d_q     <= res_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    assign inv_start = inv_start_q;
    assign inv_a     = op_a_q;
    assign inv_b     = op_b_q;
    assign inv_c     = op_c_q;
    assign inv_d     = op_d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = job_id_q;
    assign rsp_a     = res_a_q;
    assign rsp_b     = res_b_q;
    assign rsp_c     = res_c_q;
    assign rsp_d     = res_d_q;
    assign rsp_error = rsp_error_q;
    assign rsp_tmo   = rsp_tmo_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_matrix_inv_sched.sv
// Bench for matrix_inv_sched: table of jobs plus round-robin, timeout,
// backpressure and mid-job reset sequences, checked through a response scoreboard.
module tb_matrix_inv_sched;
    import matrix_inv_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid, req_ready;
    logic [NREQ*DW-1:0] req_a, req_b, req_c, req_d;
    logic               inv_start;
    logic [DW-1:0]      inv_a, inv_b, inv_c, inv_d;
    logic               inv_done;
    logic [DW-1:0]      inv_a_inv, inv_b_inv, inv_c_inv, inv_d_inv;
    logic               inv_error;
    logic               rsp_valid, rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_a, rsp_b, rsp_c, rsp_d;
    logic               rsp_error, rsp_tmo, busy;

    matrix_inv_sched #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .inv_start(inv_start), .inv_a(inv_a), .inv_b(inv_b), .inv_c(inv_c), .inv_d(inv_d),
        .inv_done(inv_done), .inv_a_inv(inv_a_inv), .inv_b_inv(inv_b_inv),
        .inv_c_inv(inv_c_inv), .inv_d_inv(inv_d_inv), .inv_error(inv_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_c(rsp_c), .rsp_d(rsp_d),
        .rsp_error(rsp_error), .rsp_tmo(rsp_tmo), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] a, b, c, d;
        logic        err, tmo;
        int          acc;
    } exp_t;

    typedef struct {
        int          kind;   // 0 = raise request, 1 = drop all requests
        int          port;
        logic [15:0] a, b, c, d;
        exp_t        e;
    } cmd_t;

    typedef struct {
        int          port;
        logic [15:0] a, b, c, d;
        logic [15:0] ea, eb, ec, ed;
        logic        eerr;
        int          lat;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   resp_cnt = 0;
    int   last_lat = 0;
    int   n_start = 0;
    int   core_mode = 0;   // 0 = answer after core_lat cycles, 2 = never answer
    int   core_lat = 1;
    logic [15:0] cap_a;
    logic [NREQ-1:0] hold;
    exp_t port_exp [NREQ];
    exp_t sb [$];
    cmd_t cmd_q [$];
    int   grant_log [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic post(input int p, input logic [15:0] a, b, c, d,
                        input logic [15:0] ea, eb, ec, ed, input logic eerr, etmo);
        cmd_t cm;
        cm.kind = 0; cm.port = p; cm.a = a; cm.b = b; cm.c = c; cm.d = d;
        cm.e.id = p; cm.e.a = ea; cm.e.b = eb; cm.e.c = ec; cm.e.d = ed;
        cm.e.err = eerr; cm.e.tmo = etmo; cm.e.acc = 0;
        cmd_q.push_back(cm);
    endtask

    task automatic clear_all();
        cmd_t cm;
        cm.kind = 1; cm.port = 0; cm.a = '0; cm.b = '0; cm.c = '0; cm.d = '0;
        cm.e.id = 0; cm.e.a = '0; cm.e.b = '0; cm.e.c = '0; cm.e.d = '0;
        cm.e.err = 1'b0; cm.e.tmo = 1'b0; cm.e.acc = 0;
        cmd_q.push_back(cm);
    endtask

    task automatic wait_resp(input int target, input int budget);
        int n = 0;
        while (resp_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_resp_bound", 64'(resp_cnt >= target), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Core model: answers with the adjugate (exact inverse when det = 1.0) and
    // flags singular when a*d == b*c; junk results on error must be masked by the DUT.
    initial begin
        logic [15:0] cb, cc, cd;
        inv_done = 1'b0; inv_error = 1'b0;
        inv_a_inv = '0; inv_b_inv = '0; inv_c_inv = '0; inv_d_inv = '0;
        forever begin
            @(negedge clk);
            if (inv_start === 1'b1 && !reset) begin
                n_start++;
                cap_a = inv_a; cb = inv_b; cc = inv_c; cd = inv_d;
                if (core_mode == 0) begin
                    repeat (core_lat) @(posedge clk);
                    #1;
                    inv_a_inv = cd;
                    inv_b_inv = -cb;
                    inv_c_inv = -cc;
                    inv_d_inv = cap_a;
                    inv_error = (int'($signed(cap_a)) * int'($signed(cd)) ==
                                 int'($signed(cb)) * int'($signed(cc)));
                    inv_done  = 1'b1;
                    @(posedge clk);
                    #1;
                    inv_done  = 1'b0;
                    inv_error = 1'b0;
                end
            end
        end
    end

    // Requester side: owns req_valid/operands, logs accepts into the scoreboard.
    initial begin
        cmd_t cm;
        exp_t e;
        int   g;
        int   drop;
        req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_d = '0;
        drop = -1;
        forever begin
            @(posedge clk);
            #1;
            if (drop >= 0 && !hold[drop]) req_valid[drop] = 1'b0;
            drop = -1;
            while (cmd_q.size() > 0) begin
                cm = cmd_q.pop_front();
                if (cm.kind == 1) begin
                    req_valid = '0;
                end else begin
                    req_a[cm.port*DW +: DW] = cm.a;
                    req_b[cm.port*DW +: DW] = cm.b;
                    req_c[cm.port*DW +: DW] = cm.c;
                    req_d[cm.port*DW +: DW] = cm.d;
                    port_exp[cm.port] = cm.e;
                    req_valid[cm.port] = 1'b1;
                end
            end
            @(negedge clk);
            if (req_ready != '0) begin
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                chk("grant_onehot", 64'($onehot(req_ready)), 1);
                chk("grant_has_valid", 64'(req_valid[g]), 1);
                e = port_exp[g];
                e.acc = cyc;
                sb.push_back(e);
                grant_log.push_back(g);
                drop = g;
            end
        end
    end

    // Response side: pops the scoreboard on every handshake.
    initial begin
        exp_t e;
        bit   seen;
        int   rise;
        seen = 0; rise = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 0;
            end else begin
                if (rsp_valid && !seen) begin
                    seen = 1;
                    rise = cyc;
                end
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_a", 64'(rsp_a), 64'(e.a));
                        chk("rsp_b", 64'(rsp_b), 64'(e.b));
                        chk("rsp_c", 64'(rsp_c), 64'(e.c));
                        chk("rsp_d", 64'(rsp_d), 64'(e.d));
                        chk("rsp_error", 64'(rsp_error), 64'(e.err));
                        chk("rsp_tmo", 64'(rsp_tmo), 64'(e.tmo));
                        last_lat = rise - e.acc;
                    end
                    resp_cnt++;
                    seen = 0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [5];
        int   s0, base, n;

        vt[0] = '{1, ONE_Q214, 16'h0000, 16'h0000, ONE_Q214, ONE_Q214, 16'h0000, 16'h0000, ONE_Q214, 1'b0, 1};
        vt[1] = '{0, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1};
        vt[2] = '{2, 16'h4000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 16'hE000, 16'h0000, 16'h4000, 1'b0, 3};
        vt[3] = '{3, 16'h4000, 16'h0000, 16'h1000, 16'h4000, 16'h4000, 16'h0000, 16'hF000, 16'h4000, 1'b0, 5};
        vt[4] = '{0, 16'h2000, 16'h1000, 16'h4000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 2};

        reset = 1'b1; rsp_ready = 1'b1; hold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_rsp_valid", 64'(rsp_valid), 0);
        chk("reset_inv_start", 64'(inv_start), 0);
        chk("reset_req_ready", 64'(req_ready), 0);
        chk("reset_inv_a", 64'(inv_a), 0);
        chk("reset_rsp_a", 64'(rsp_a), 0);
        chk("reset_rsp_id", 64'(rsp_id), 0);
        chk("reset_rsp_error", 64'(rsp_error), 0);
        chk("reset_rsp_tmo", 64'(rsp_tmo), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Round-robin: ports 0,2,3 keep requesting from reset.
        core_mode = 0; core_lat = 2;
        hold = 4'b1101;
        post(0, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0);
        post(2, 16'h4000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 16'hE000, 16'h0000, 16'h4000, 1'b0, 1'b0);
        post(3, 16'h4000, 16'h0000, 16'h1000, 16'h4000, 16'h4000, 16'h0000, 16'hF000, 16'h4000, 1'b0, 1'b0);
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        hold = '0;
        clear_all();
        wait_resp(4, 200);
        chk("rr_grants", 64'(grant_log.size()), 4);
        if (grant_log.size() >= 4) begin
            chk("rr_grant0", 64'(grant_log[0]), 0);
            chk("rr_grant1", 64'(grant_log[1]), 2);
            chk("rr_grant2", 64'(grant_log[2]), 3);
            chk("rr_grant3", 64'(grant_log[3]), 0);
        end

        // Table-driven single jobs.
        for (int i = 0; i < 5; i++) begin
            core_lat = vt[i].lat;
            s0 = n_start;
            post(vt[i].port, vt[i].a, vt[i].b, vt[i].c, vt[i].d,
                 vt[i].ea, vt[i].eb, vt[i].ec, vt[i].ed, vt[i].eerr, 1'b0);
            wait_resp(resp_cnt + 1, 200);
            chk("vec_latency", 64'(last_lat), 64'(2 + vt[i].lat));
            chk("vec_starts", 64'(n_start - s0), 1);
            chk("vec_core_a", 64'(cap_a), 64'(vt[i].a));
        end

        // Timeout, then a normal job proves the scheduler recovers.
        core_mode = 2;
        post(2, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_resp(resp_cnt + 1, 200);
        chk("tmo_latency", 64'(last_lat), 64'(TMO + 2));
        core_mode = 0; core_lat = 1;
        post(3, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0);
        wait_resp(resp_cnt + 1, 200);
        chk("post_tmo_latency", 64'(last_lat), 3);

        // Backpressure: response held 5 cycles while another port waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        base = grant_log.size();
        post(2, 16'h4000, 16'h2000, 16'h0000, 16'h4000, 16'h4000, 16'hE000, 16'h0000, 16'h4000, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid_seen", 64'(rsp_valid), 1);
        post(0, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid), 1);
            chk("bp_hold_id", 64'(rsp_id), 2);
            chk("bp_hold_b", 64'(rsp_b), 64'(16'hE000));
            chk("bp_no_ready", 64'(req_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_resp(resp_cnt + 2, 200);
        chk("bp_grants", 64'(grant_log.size() - base), 2);
        if (grant_log.size() >= base + 2) begin
            chk("bp_first", 64'(grant_log[base]), 2);
            chk("bp_second", 64'(grant_log[base + 1]), 0);
        end

        // Reset while the core is stuck in WAIT; rr pointer must return to 0.
        core_mode = 2;
        base = grant_log.size();
        post(3, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        n = 0;
        while (grant_log.size() == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy), 1);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_inv_start", 64'(inv_start), 0);
        chk("arst_rsp_valid", 64'(rsp_valid), 0);
        chk("arst_inv_a", 64'(inv_a), 0);
        chk("arst_req_ready", 64'(req_ready), 0);
        core_mode = 0; core_lat = 1;
        clear_all();
        post(0, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 1'b0);
        post(2, 16'h4000, 16'h0000, 16'h1000, 16'h4000, 16'h4000, 16'h0000, 16'hF000, 16'h4000, 1'b0, 1'b0);
        base = grant_log.size();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold_rsp_valid", 64'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        wait_resp(resp_cnt + 2, 200);
        chk("rst_grants", 64'(grant_log.size() - base), 2);
        if (grant_log.size() >= base + 2) begin
            chk("rst_first_grant", 64'(grant_log[base]), 0);
            chk("rst_second_grant", 64'(grant_log[base + 1]), 2);
        end
        repeat (3) @(negedge clk);
        chk("end_idle", 64'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
